// File: rtl/icache_pkg.sv
// ============================================================================
//  icache_pkg : shared geometry, widths and FSM encoding for the I-cache refill
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

   localparam int PAGE_BITS  = 12;
   localparam int BEAT_BYTES = 8;
   localparam int BEATS      = (1 << PAGE_BITS) / BEAT_BYTES;
   localparam int TAG_W      = 64 - PAGE_BITS;
   localparam int IDX_W      = $clog2(BEATS);
   localparam int OFF_W      = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/icache_beat_ctr.sv
// ============================================================================
//  icache_beat_ctr : wrapping beat index plus an independent remaining-beat
//                    count, so a refill can start mid-page and still end.
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module icache_beat_ctr
   import icache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic [IDX_W-1:0] start_idx_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o
);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] rem_q, rem_d;

   always_comb begin
      idx_d = idx_q;
      rem_d = rem_q;
      if (load_i) begin
         idx_d = start_idx_i;
         rem_d = IDX_W'(BEATS - 1);
      end else if (adv_i) begin
         // index wraps modulo BEATS through natural overflow
         idx_d = idx_q + IDX_W'(1);
         rem_d = rem_q - IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         rem_q <= '0;
      end else begin
         idx_q <= idx_d;
         rem_q <= rem_d;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = (rem_q == '0);

endmodule

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
//  icache_refill_ctrl : page refill sequencer between fetch, cache arrays and
//                       the memory bus. Option: ICACHE_CRITICAL_WORD_FIRST_EN
//  Revision           : 1.0
// ============================================================================
`default_nettype none

module icache_refill_ctrl
   import icache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             miss_valid,
   input  logic [63:0]      miss_addr,
   input  logic             flush,
   output logic             busy,
   output logic             mem_req,
   output logic [63:0]      mem_addr,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [63:0]      mem_rdata,
   output logic             arr_we,
   output logic [IDX_W-1:0] arr_idx,
   output logic [63:0]      arr_wdata,
   output logic             tag_we,
   output logic [TAG_W-1:0] tag_wdata,
   output logic             tag_valid
);

   state_e           state_q, state_d;
   logic [TAG_W-1:0] base_q, base_d;
   logic             tag_valid_q, tag_valid_d;
   logic             drop_q, drop_d;

   logic             w_ctr_load;
   logic             w_ctr_adv;
   logic             w_ctr_last;
   logic [IDX_W-1:0] w_ctr_idx;
   logic [IDX_W-1:0] w_start_idx;
   logic             w_unused_addr;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   assign w_start_idx = miss_addr[PAGE_BITS-1:OFF_W];
`else
   assign w_start_idx = '0;
`endif
   assign w_unused_addr = ^miss_addr[PAGE_BITS-1:0];

   icache_beat_ctr u_beat_ctr (
      .clk         (clk),
      .rst         (rst),
      .load_i      (w_ctr_load),
      .adv_i       (w_ctr_adv),
      .start_idx_i (w_start_idx),
      .idx_o       (w_ctr_idx),
      .last_o      (w_ctr_last)
   );

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      tag_valid_d = tag_valid_q;
      drop_d      = drop_q;
      w_ctr_load  = 1'b0;
      w_ctr_adv   = 1'b0;
      mem_req     = 1'b0;
      arr_we      = 1'b0;
      tag_we      = 1'b0;

      if (flush) tag_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (miss_valid && !flush) begin
               base_d      = miss_addr[63:PAGE_BITS];
               tag_valid_d = 1'b0;
               drop_d      = 1'b0;
               w_ctr_load  = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               mem_req = 1'b1;
               if (mem_gnt) state_d = WAIT;
            end
         end
         WAIT: begin
            // the outstanding read must drain before a flush can retire
            if (flush) drop_d = 1'b1;
            if (mem_rvalid) begin
               if (flush || drop_q) begin
                  drop_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  arr_we = 1'b1;
                  if (w_ctr_last) begin
                     state_d = COMMIT;
                  end else begin
                     w_ctr_adv = 1'b1;
                     state_d   = REQ;
                  end
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (!flush) begin
               tag_we      = 1'b1;
               tag_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         tag_valid_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         tag_valid_q <= tag_valid_d;
         drop_q      <= drop_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign mem_addr  = {base_q, w_ctr_idx, {OFF_W{1'b0}}};
   assign arr_idx   = w_ctr_idx;
   assign arr_wdata = arr_we ? mem_rdata : '0;
   assign tag_wdata = base_q;
   assign tag_valid = tag_valid_q;

endmodule

`default_nettype wire
